// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the EX-stage M-extension unit:
// funct3 encodings, default datapath width, FSM encoding and signedness helpers.
package riscv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_div_op(input logic [2:0] fnc3);
    return fnc3[2];
  endfunction

  function automatic logic a_is_signed(input logic [2:0] fnc3);
    return (fnc3 != F3_MULHU) && (fnc3 != F3_DIVU) && (fnc3 != F3_REMU);
  endfunction

  function automatic logic b_is_signed(input logic [2:0] fnc3);
    return (fnc3 == F3_MUL) || (fnc3 == F3_MULH) || (fnc3 == F3_DIV) || (fnc3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Maps unsigned magnitude results (product, quotient, remainder) back to the
// signed domain and selects the architectural result for the funct3.
module muldiv_sign_fix
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2*XLEN-1:0] prod_i,
  input  logic [XLEN-1:0]   quo_i,
  input  logic [XLEN-1:0]   rem_i,
  input  logic              sign_a_i,
  input  logic              sign_b_i,
  input  logic [2:0]        fnc3_i,
  output logic [XLEN-1:0]   result_o
);

  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;

  // Remainder follows the dividend; product and quotient follow the sign xor
  always_comb begin
    prod_s = (sign_a_i ^ sign_b_i) ? -prod_i : prod_i;
    quo_s  = (sign_a_i ^ sign_b_i) ? -quo_i  : quo_i;
    rem_s  = sign_a_i ? -rem_i : rem_i;
    case (fnc3_i)
      F3_MUL:                       result_o = prod_s[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: result_o = prod_s[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:              result_o = quo_s;
      F3_REM, F3_REMU:              result_o = rem_s;
      default:                      result_o = {XLEN{1'b0}};
    endcase
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit in EX: one radix-2 step per cycle,
// stalls the front of the pipe while busy and pulses done_o for one cycle.
module ex_muldiv_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic [2:0]      fnc3_i,
  input  logic [XLEN-1:0] op_a_i,
  input  logic [XLEN-1:0] op_b_i,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  localparam int CW = $clog2(XLEN);

  md_state_e          state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic [2:0]         fnc3_q, fnc3_d;
  logic               sign_a_q, sign_a_d;
  logic               sign_b_q, sign_b_d;
  logic [XLEN-1:0]    opa_q, opa_d;
  logic [XLEN-1:0]    opb_q, opb_d;
  logic [2*XLEN-1:0]  acc_q, acc_d;
  logic [XLEN-1:0]    quo_q, quo_d;
  logic [XLEN-1:0]    rem_q, rem_d;
  logic [XLEN-1:0]    result_q, result_d;
  logic               done_q, done_d;

  logic               a_sgn_s, b_sgn_s;
  logic [XLEN-1:0]    a_mag_s, b_mag_s;
  logic               div_zero_s, div_ovf_s;
  logic [XLEN-1:0]    special_res_s;
  logic [XLEN:0]      mul_sum_s;
  logic [2*XLEN-1:0]  mul_next_s;
  logic [XLEN:0]      rem_shift_s;
  logic [XLEN:0]      rem_diff_s;
  logic               div_ge_s;
  logic [XLEN-1:0]    rem_next_s;
  logic [XLEN-1:0]    quo_next_s;
  logic [XLEN-1:0]    fix_res_s;

  // Operand sign/magnitude extraction and one-cycle special-case results
  always_comb begin
    a_sgn_s    = op_a_i[XLEN-1] & a_is_signed(fnc3_i);
    b_sgn_s    = op_b_i[XLEN-1] & b_is_signed(fnc3_i);
    a_mag_s    = a_sgn_s ? -op_a_i : op_a_i;
    b_mag_s    = b_sgn_s ? -op_b_i : op_b_i;
    div_zero_s = (op_b_i == {XLEN{1'b0}});
    div_ovf_s  = ((fnc3_i == F3_DIV) || (fnc3_i == F3_REM)) &&
                 (op_a_i == {1'b1, {(XLEN-1){1'b0}}}) &&
                 (op_b_i == {XLEN{1'b1}});
    if (div_zero_s) begin
      special_res_s = fnc3_i[1] ? op_a_i : {XLEN{1'b1}};
    end else begin
      special_res_s = fnc3_i[1] ? {XLEN{1'b0}} : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Single radix-2 step: shift-add multiply and restoring divide
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                  (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
    mul_next_s  = {mul_sum_s, acc_q[XLEN-1:1]};
    rem_shift_s = {rem_q, quo_q[XLEN-1]};
    rem_diff_s  = rem_shift_s - {1'b0, opb_q};
    div_ge_s    = (rem_shift_s >= {1'b0, opb_q});
    rem_next_s  = div_ge_s ? rem_diff_s[XLEN-1:0] : rem_shift_s[XLEN-1:0];
    quo_next_s  = {quo_q[XLEN-2:0], div_ge_s};
  end

  // The fix-up sees the post-step values so the last step lands in result_q directly
  muldiv_sign_fix #(
    .XLEN (XLEN)
  ) u_sign_fix (
    .prod_i   (mul_next_s),
    .quo_i    (quo_next_s),
    .rem_i    (rem_next_s),
    .sign_a_i (sign_a_q),
    .sign_b_i (sign_b_q),
    .fnc3_i   (fnc3_q),
    .result_o (fix_res_s)
  );

  // Next-state and datapath update
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    fnc3_d   = fnc3_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          fnc3_d   = fnc3_i;
          sign_a_d = a_sgn_s;
          sign_b_d = b_sgn_s;
          opa_d    = a_mag_s;
          opb_d    = b_mag_s;
          acc_d    = {{XLEN{1'b0}}, b_mag_s};
          quo_d    = a_mag_s;
          rem_d    = {XLEN{1'b0}};
          count_d  = {CW{1'b0}};
          if (is_div_op(fnc3_i) && (div_zero_s || div_ovf_s)) begin
            state_d  = DONE;
            result_d = special_res_s;
            done_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          count_d = count_q + CW'(1);
          if (is_div_op(fnc3_q)) begin
            quo_d = quo_next_s;
            rem_d = rem_next_s;
          end else begin
            acc_d = mul_next_s;
          end
          if (count_q == CW'(XLEN-1)) begin
            state_d  = DONE;
            result_d = fix_res_s;
            done_d   = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      // The instruction still sitting in ID/EX is the one just completed
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= {CW{1'b0}};
      fnc3_q   <= 3'b000;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opa_q    <= {XLEN{1'b0}};
      opb_q    <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      quo_q    <= {XLEN{1'b0}};
      rem_q    <= {XLEN{1'b0}};
      result_q <= {XLEN{1'b0}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      fnc3_q   <= fnc3_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign stall_o  = ((state_q == IDLE) && start_i && !flush_i) || (state_q == RUN);
  assign done_o   = done_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed corner cases, random
// operations against an arithmetic reference, back-to-back, flush and reset.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  fnc3_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        stall_o;
  logic        done_o;
  logic [31:0] result_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] last_res;

  ex_muldiv_unit dut (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start_i),
    .flush_i  (flush_i),
    .fnc3_i   (fnc3_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .stall_o  (stall_o),
    .done_o   (done_o),
    .result_o (result_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference result straight from the RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    longint unsigned pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin pu = longint'(ua) * longint'(ub); return pu[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub;
        return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        p = sa % sb;
        return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub;
        return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                     input logic [31:0] b);
    if (f >= 3'd4 && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  // Issue at the current sample point, then follow the op until done_o
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input bit hold);
    int lat;
    bit got_done;
    logic [31:0] exp;
    exp      = ref_model(f, a, b);
    fnc3_i   = f;
    op_a_i   = a;
    op_b_i   = b;
    start_i  = 1'b1;
    #1;
    check_val("issue_stall", stall_o, 32'd1);
    lat      = 0;
    got_done = 1'b0;
    for (int n = 1; n <= 40 && !got_done; n++) begin
      @(posedge clk);
      #1;
      if (done_o) begin
        got_done = 1'b1;
        lat      = n;
      end else begin
        check_val("run_stall", stall_o, 32'd1);
      end
    end
    check_val($sformatf("latency f%0d", f), lat, ref_latency(f, a, b));
    if (got_done) begin
      check_val($sformatf("result f%0d %h %h", f, a, b), result_o, exp);
      check_val("done_stall", stall_o, 32'd0);
    end
    last_res = exp;
    if (!hold) start_i = 1'b0;
  endtask

  task automatic do_op_idle(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    do_op(f, a, b, 1'b0);
    @(posedge clk);
    #1;
    check_val("after_done", done_o, 32'd0);
  endtask

  logic [2:0]  dir_f [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                              3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] dir_a [12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                              32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] dir_b [12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2,
                              32'd2, 32'd2, 32'd7, 32'd7,
                              32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

  initial begin
    int seen;
    rst     = 1'b0;
    start_i = 1'b0;
    flush_i = 1'b0;
    fnc3_i  = 3'd0;
    op_a_i  = 32'd0;
    op_b_i  = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_done", done_o, 32'd0);
    check_val("rst_result", result_o, 32'd0);
    check_val("rst_stall", stall_o, 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases from the RV32M corner list
    check_val("spec_mul_ref", ref_model(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    for (int i = 0; i < 12; i++) do_op_idle(dir_f[i], dir_a[i], dir_b[i]);

    // Random operations
    for (int i = 0; i < 40; i++) begin
      logic [2:0] f;
      logic [31:0] a, b;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      do_op_idle(f, a, b);
    end

    // Back-to-back: MUL stays in ID/EX through DONE, DIV follows
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
    @(posedge clk);
    #1;
    check_val("b2b_no_retrig", done_o, 32'd0);
    do_op_idle(3'd4, 32'hFFFF_FFF9, 32'd2);

    // Flush during RUN
    fnc3_i  = 3'd0;
    op_a_i  = 32'd12345;
    op_b_i  = 32'd678;
    start_i = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
    end
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    #1;
    check_val("flush_stall", stall_o, 32'd0);
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done_o) seen++;
    end
    check_val("flush_no_done", seen, 32'd0);
    check_val("flush_result_kept", result_o, last_res);

    // Flush together with start in IDLE must not start anything
    start_i = 1'b1;
    flush_i = 1'b1;
    #1;
    check_val("idle_flush_stall", stall_o, 32'd0);
    @(posedge clk);
    #1;
    start_i = 1'b0;
    flush_i = 1'b0;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done_o) seen++;
    end
    check_val("idle_flush_no_done", seen, 32'd0);

    // Reset in the middle of a divide
    fnc3_i  = 3'd5;
    op_a_i  = 32'd100;
    op_b_i  = 32'd7;
    start_i = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(posedge clk);
      #1;
    end
    rst     = 1'b0;
    start_i = 1'b0;
    #1;
    check_val("midrst_done", done_o, 32'd0);
    check_val("midrst_result", result_o, 32'd0);
    check_val("midrst_stall", stall_o, 32'd0);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done_o) seen++;
    end
    check_val("midrst_no_done", seen, 32'd0);
    do_op_idle(3'd7, 32'd100, 32'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
